// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
// Signal names match the arbiter's documented port names; clk and rst stay outside.
interface rr_arbiter8_if;
    logic [7:0] iReq;
    logic       iDone;
    logic [7:0] oGrant;
    logic [2:0] oGrantId;
    logic       oValid;
    logic       oTimeout;

    modport master (
        output iReq,
        output iDone,
        input  oGrant,
        input  oGrantId,
        input  oValid,
        input  oTimeout
    );

    modport slave (
        input  iReq,
        input  iDone,
        output oGrant,
        output oGrantId,
        output oValid,
        output oTimeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary grant index,
// owner release via done / request drop, and an optional hold-limit timeout.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter8_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value seen in the last permitted cycle of a grant.
    localparam int unsigned           HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0]     HOLD_LAST   = HOLD_W'(HOLD_LAST_I);
    localparam bit                    HOLD_EN     = (MAX_HOLD != 0);

    state_t            state_q;
    logic [7:0]        grant_q;
    logic [2:0]        grant_id_q;
    logic [2:0]        ptr_q;
    logic              valid_q;
    logic              timeout_q;
    logic [HOLD_W-1:0] cnt_q;

    logic [2:0]        cand_d;
    logic [2:0]        win_id_d;
    logic              win_found_d;
    logic              rel_done_d;
    logic              rel_drop_d;
    logic              rel_hold_d;
    logic              release_d;
    logic              timeout_d;

    // Winner search: first set request scanning upward from the pointer, wrapping at 8.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        cand_d      = ptr_q;
        win_id_d    = ptr_q;
        win_found_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand_d = ptr_q + 3'(i);
            if (!win_found_d && bus.iReq[cand_d]) begin
                win_found_d = 1'b1;
                win_id_d    = cand_d;
            end
        end
    end

    always_comb begin
        rel_done_d = bus.iDone;
        rel_drop_d = ~bus.iReq[grant_id_q];
        rel_hold_d = HOLD_EN && (cnt_q == HOLD_LAST);
        release_d  = rel_done_d | rel_drop_d | rel_hold_d;
        timeout_d  = rel_hold_d & ~rel_done_d & ~rel_drop_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 8'h00;
            grant_id_q <= 3'd0;
            ptr_q      <= 3'd0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q    <= GRANT;
                        grant_q    <= 8'd1 << win_id_d;
                        grant_id_q <= win_id_d;
                        valid_q    <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q    <= IDLE;
                        grant_q    <= 8'h00;
                        grant_id_q <= 3'd0;
                        valid_q    <= 1'b0;
                        ptr_q      <= grant_id_q + 3'd1;
                        timeout_q  <= timeout_d;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oGrant   = grant_q;
    assign bus.oGrantId = grant_id_q;
    assign bus.oValid   = valid_q;
    assign bus.oTimeout = timeout_q;

endmodule
